mul10_seq: RTL and testbench



---
 rtl/mul10_seq.sv | 135 +++++++++++++
 tb/tb_mul10_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul10_seq.sv
// Sequenced 10x10 unsigned multiplier: four 5x5 partial products are pushed
// through one shared Wallace-tree multiplier and summed into a 20-bit accumulator.

module mul5x5_wallace (
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [9:0] p,
  output logic       cout
);

  logic [10:0] row [5];
  logic [10:0] s1, c1, s2, c2, s3, c3;

  function automatic logic [10:0] csa_sum(input logic [10:0] u, v, w);
    return u ^ v ^ w;
  endfunction

  function automatic logic [10:0] csa_carry(input logic [10:0] u, v, w);
    return ((u & v) | (u & w) | (v & w)) << 1;
  endfunction

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      row[i] = y[i] ? (11'(x) << i) : 11'd0;
    end
  end

  // Three carry-save levels reduce five rows to two, then one carry-propagate add.
  assign s1 = csa_sum(row[0], row[1], row[2]);
  assign c1 = csa_carry(row[0], row[1], row[2]);
  assign s2 = csa_sum(s1, c1, row[3]);
  assign c2 = csa_carry(s1, c1, row[3]);
  assign s3 = csa_sum(s2, c2, row[4]);
  assign c3 = csa_carry(s2, c2, row[4]);

  assign {cout, p} = s3 + c3;

endmodule

module mul10_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] product,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LL, LH, HL, HH, DONE} state_t;

  state_t      state, state_nx;
  logic [9:0]  a_r, b_r;
  logic [4:0]  mx, my;
  logic [9:0]  pp;
  logic        pp_cout;
  logic [19:0] pp_ext, addend, acc;

  mul5x5_wallace u_mul (
    .x    (mx),
    .y    (my),
    .p    (pp),
    .cout (pp_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = LL;
      LL:      state_nx = LH;
      LH:      state_nx = HL;
      HL:      state_nx = HH;
      HH:      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // cout is always zero for 5-bit operands, so folding it into the add is free.
  assign pp_ext = 20'({pp_cout, pp});

  always_comb begin
    mx     = a_r[4:0];
    my     = b_r[4:0];
    addend = 20'd0;
    case (state)
      LL: addend = pp_ext;
      LH: begin
        my     = b_r[9:5];
        addend = pp_ext << 5;
      end
      HL: begin
        mx     = a_r[9:5];
        addend = pp_ext << 5;
      end
      HH: begin
        mx     = a_r[9:5];
        my     = b_r[9:5];
        addend = pp_ext << 10;
      end
      default: addend = 20'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= 20'd0;
      a_r <= 10'd0;
      b_r <= 10'd0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
        acc <= 20'd0;
      end
    end else begin
      acc <= acc + addend;
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_mul10_seq.sv
// Directed bench for mul10_seq: vector table plus backpressure, streaming and
// mid-operation reset sequences.

module tb_mul10_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] product;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  mul10_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  va;
    logic [9:0]  vb;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Waits for in_ready, accepts one operand pair, scrambles a/b during the
  // computation, then checks latency and product and completes the handshake.
  task automatic run_op(input logic [9:0] va, input logic [9:0] vb, input logic [19:0] exp,
                        input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({name, " ready_before_accept"}, in_ready, 1);
    in_valid = 1'b1; a = va; b = vb; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      a = 10'($urandom); b = 10'($urandom);
      step(); n++;
    end
    chk({name, " latency"}, n, 4);
    chk({name, " product"}, product, exp);
    step();
    chk({name, " in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    int n, gap, seen;
    vecs[0] = '{10'd0,    10'd0,    20'd0};
    vecs[1] = '{10'd1023, 10'd1023, 20'd1046529};
    vecs[2] = '{10'd37,   10'd21,   20'd777};
    vecs[3] = '{10'd512,  10'd2,    20'd1024};
    vecs[4] = '{10'd32,   10'd32,   20'd1024};
    vecs[5] = '{10'd31,   10'd33,   20'd1023};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset product", product, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: hold out_ready low for three DONE cycles with stray in_valid.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 10'd100; b = 10'd300;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("bp latency", n, 4);
    for (int k = 0; k < 3; k++) begin
      chk("bp product_hold", product, 30000);
      chk("bp out_valid_hold", out_valid, 1);
      in_valid = 1'b1; a = 10'd7; b = 10'd9;
      step();
    end
    chk("bp product_last", product, 30000);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp out_valid_after", out_valid, 0);
    chk("bp in_ready_after", in_ready, 1);
    chk("bp product_kept", product, 30000);

    // Continuous stream with in_valid held high.
    in_valid = 1'b1; a = 10'd3; b = 10'd5;
    step();
    a = 10'd1000; b = 10'd999;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("stream first", product, 15);
    gap = 0;
    step(); gap++;
    while (!out_valid && gap < 20) begin step(); gap++; end
    in_valid = 1'b0;
    chk("stream gap", gap, 6);
    chk("stream second", product, 999000);
    step();

    // Reset asserted while the FSM sits in HL.
    in_valid = 1'b1; a = 10'd1023; b = 10'd1023;
    step();
    in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst product", product, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      step();
    end
    chk("midrst no_out_valid", seen, 0);
    run_op(10'd2, 10'd3, 20'd6, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
